// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button one-shot generator.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } btn_state_e;

  // Level of the normalised (post-polarity) button signal when pressed.
  localparam logic BTN_PRESSED = 1'b1;

  function automatic int db_cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for the asynchronous button pin; reset value is the released pin level.
module btn_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_oneshot_gen.sv
// Debounced push button to single-cycle press pulse; optional auto-repeat when BTN_AUTO_REPEAT_EN is defined.
// oBtnPulse is a one-cycle strobe with no back-pressure: the consumer must sample it every cycle.
module btn_oneshot_gen
  import btn_pkg::*;
#(
  parameter int cDebounceCycles = 16,
  parameter bit cBtnActiveLow   = 1'b1,
  parameter int cRepeatDelay    = 64,
  parameter int cRepeatPeriod   = 16
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       iBtnRaw,
  output logic       oBtnPulse,
  output logic       oBtnLevel,
  output logic [7:0] oPressCnt,
  output btn_state_e oDbgState
);

  localparam int   DB_W         = db_cnt_width(cDebounceCycles);
  localparam logic RAW_RELEASED = cBtnActiveLow ? 1'b1 : 1'b0;

  if (cDebounceCycles < 2 || cRepeatPeriod < 1 || cRepeatPeriod > cRepeatDelay) begin : g_bad_cfg
    $error("btn_oneshot_gen: invalid debounce/repeat configuration");
  end

  logic raw_sync;
  logic s_btn;

  btn_sync #(
    .RESET_VAL(RAW_RELEASED)
  ) u_sync (
    .clk_i (CLK),
    .rst_ni(RESETn),
    .d_i   (iBtnRaw),
    .q_o   (raw_sync)
  );

  assign s_btn = (raw_sync != RAW_RELEASED) ? BTN_PRESSED : ~BTN_PRESSED;

  btn_state_e      state_q, state_d;
  logic [DB_W-1:0] db_q, db_d;
  logic            pulse_q, pulse_d;
  logic            level_q, level_d;
  logic [7:0]      cnt_q, cnt_d;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int REP_W = $clog2(cRepeatDelay) + 1;
  logic [REP_W-1:0] rep_q, rep_d;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) rep_q <= '0;
    else         rep_q <= rep_d;
  end
`endif

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      db_q    <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    pulse_d = 1'b0;
    level_d = level_q;
`ifdef BTN_AUTO_REPEAT_EN
    rep_d   = rep_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef BTN_AUTO_REPEAT_EN
        rep_d = '0;
`endif
        if (s_btn) begin
          state_d = PRESS_DB;
          db_d    = DB_W'(1);
        end else begin
          db_d    = '0;
        end
      end
      PRESS_DB: begin
        if (!s_btn) begin
          state_d = IDLE;
          db_d    = '0;
        end else if (db_q == DB_W'(cDebounceCycles - 1)) begin
          state_d = HELD;
          db_d    = '0;
          pulse_d = 1'b1;
          level_d = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          db_d    = db_q + DB_W'(1);
        end
      end
      HELD: begin
        if (!s_btn) begin
          state_d = RELEASE_DB;
          db_d    = DB_W'(1);
        end else begin
`ifdef BTN_AUTO_REPEAT_EN
          // Reload to Delay-Period so later repeats reuse the same terminal compare.
          if (rep_q == REP_W'(cRepeatDelay - 1)) begin
            pulse_d = 1'b1;
            rep_d   = REP_W'(cRepeatDelay - cRepeatPeriod);
          end else begin
            rep_d   = rep_q + REP_W'(1);
          end
`endif
        end
      end
      RELEASE_DB: begin
        if (s_btn) begin
          state_d = HELD;
          db_d    = '0;
        end else if (db_q == DB_W'(cDebounceCycles - 1)) begin
          state_d = IDLE;
          db_d    = '0;
          level_d = 1'b0;
        end else begin
          db_d    = db_q + DB_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        db_d    = '0;
        level_d = 1'b0;
      end
    endcase
    cnt_d = cnt_q + (pulse_d ? 8'd1 : 8'd0);
  end

  assign oBtnPulse = pulse_q;
  assign oBtnLevel = level_q;
  assign oPressCnt = cnt_q;
  assign oDbgState = state_q;

endmodule
